// File: rtl/adt7320_responder_pkg.sv
//------------------------------------------------------------------------------
// Module  : adt7320_responder_pkg
// Brief   : Register map, FSM encoding and reset values for the ADT7320 emulator.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package adt7320_responder_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CONFIG = 3'd1;
  localparam logic [2:0] ADDR_TEMP   = 3'd2;
  localparam logic [2:0] ADDR_ID     = 3'd3;
  localparam logic [2:0] ADDR_TCRIT  = 3'd4;
  localparam logic [2:0] ADDR_THYST  = 3'd5;
  localparam logic [2:0] ADDR_THIGH  = 3'd6;
  localparam logic [2:0] ADDR_TLOW   = 3'd7;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_RDATA  = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  localparam logic [7:0]  ID_DEFAULT    = 8'hC3;
  localparam logic [15:0] TCRIT_RESET   = 16'h4980;
  localparam logic [7:0]  THYST_RESET   = 8'h05;
  localparam logic [15:0] THIGH_RESET   = 16'h2000;
  localparam logic [15:0] TLOW_RESET    = 16'h0500;
  localparam logic [7:0]  STATUS_RESET  = 8'h80;
  localparam logic [5:0]  ONES_FOR_RST  = 6'd32;

  function automatic logic [4:0] reg_width(input logic [2:0] addr);
    logic [4:0] width;
    case (addr)
      ADDR_TEMP, ADDR_TCRIT, ADDR_THIGH, ADDR_TLOW: width = 5'd16;
      default:                                      width = 5'd8;
    endcase
    return width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adt7320_responder_if.sv
//------------------------------------------------------------------------------
// Module  : adt7320_responder_if
// Brief   : Four-wire SPI bus plus pad output-enable for the ADT7320 emulator.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface adt7320_responder_if;
  logic cs;
  logic sclk;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (output cs, output sclk, output din, input dout, input dout_oe);
  modport slave  (input cs, input sclk, input din, output dout, output dout_oe);
endinterface

`default_nettype wire

// File: rtl/adt7320_responder_spi_sync_edge.sv
//------------------------------------------------------------------------------
// Module  : spi_sync_edge
// Brief   : N-stage synchronizer with rise/fall pulses on the synchronized copy.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // Left unreset so the synchronized pin state stays valid while reset is held.
  logic [STAGES-1:0] sync_ff;
  logic              level_d;

  always_ff @(posedge clk) begin
    sync_ff <= {sync_ff[STAGES-2:0], async_in};
    level_d <= sync_ff[STAGES-1];
  end

  assign level = sync_ff[STAGES-1];
  assign rise  = sync_ff[STAGES-1] & ~level_d;
  assign fall  = ~sync_ff[STAGES-1] & level_d;

endmodule

`default_nettype wire

// File: rtl/adt7320_responder.sv
//------------------------------------------------------------------------------
// Module  : adt7320_responder
// Brief   : SPI mode-3 slave emulating an ADT7320 temperature sensor register map.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adt7320_responder
  import adt7320_responder_pkg::*;
#(
  parameter int          SYNC_STAGES   = 2,
  parameter logic [7:0]  ID_VALUE      = ID_DEFAULT,
  parameter logic [15:0] TCRIT_DEFAULT = TCRIT_RESET,
  parameter logic [7:0]  THYST_DEFAULT = THYST_RESET,
  parameter logic [15:0] THIGH_DEFAULT = THIGH_RESET,
  parameter logic [15:0] TLOW_DEFAULT  = TLOW_RESET
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        temp_in,
  input  logic               temp_valid,
  adt7320_responder_if.slave spi,
  output logic [7:0]         config_reg
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic din_s, din_rise, din_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .async_in(spi.cs), .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .async_in(spi.sclk), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .async_in(spi.din), .level(din_s), .rise(din_rise), .fall(din_fall)
  );

  logic [2:0]  state, state_next;
  logic [4:0]  bitcnt;
  logic [5:0]  ones_cnt;
  logic [6:0]  cmd_sh;
  logic [14:0] wr_sh;
  logic [15:0] shift_out;
  logic [2:0]  cur_addr;
  logic        dout_q;

  logic [15:0] temp_q, tcrit_q, thigh_q, tlow_q;
  logic [7:0]  thyst_q, config_q;
  logic        rdy_n;

  logic [7:0]  cmd_byte;
  logic [2:0]  cmd_addr;
  logic        cmd_read;
  logic [15:0] wr_word;
  logic [7:0]  status_val;
  logic [15:0] rd_word;

  logic cmd_done, wr_last, rd_shift, rd_tail;
  logic ones_hit, rd_done;

  assign cmd_byte = {cmd_sh, din_s};
  assign cmd_read = cmd_byte[6];
  assign cmd_addr = cmd_byte[5:3];
  assign wr_word  = {wr_sh, din_s};

  assign status_val = {rdy_n,
                       $signed(temp_q) >= $signed(tcrit_q),
                       $signed(temp_q) >= $signed(thigh_q),
                       $signed(temp_q) <= $signed(tlow_q),
                       4'b0000};

  always_comb begin
    rd_word = 16'h0000;
    case (cmd_addr)
      ADDR_STATUS: rd_word = {status_val, 8'h00};
      ADDR_CONFIG: rd_word = {config_q, 8'h00};
      ADDR_TEMP:   rd_word = temp_q;
      ADDR_ID:     rd_word = {ID_VALUE, 8'h00};
      ADDR_TCRIT:  rd_word = tcrit_q;
      ADDR_THYST:  rd_word = {thyst_q, 8'h00};
      ADDR_THIGH:  rd_word = thigh_q;
      default:     rd_word = tlow_q;
    endcase
  end

  // The ones counter watches every rise while selected, regardless of FSM state.
  assign ones_hit = !cs_s && sclk_rise && din_s && (ones_cnt == ONES_FOR_RST - 6'd1);
  assign rd_done  = rd_shift && (bitcnt == 5'd15) && (cur_addr == ADDR_TEMP);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_s) begin
      state_next = ST_IDLE;
    end else if (ones_hit) begin
      state_next = ST_IGNORE;
    end else begin
      case (state)
        ST_IDLE:   state_next = ST_CMD;
        ST_CMD:    if (cmd_done) state_next = cmd_read ? ST_RDATA : ST_WDATA;
        ST_WDATA:  if (wr_last) state_next = ST_IGNORE;
        ST_RDATA:  state_next = ST_RDATA;
        ST_IGNORE: state_next = ST_IGNORE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_done = 1'b0;
    wr_last  = 1'b0;
    rd_shift = 1'b0;
    rd_tail  = 1'b0;
    if (!cs_s) begin
      case (state)
        ST_CMD:   cmd_done = sclk_rise && (bitcnt == 5'd7);
        ST_WDATA: wr_last  = sclk_rise && (bitcnt == reg_width(cur_addr) - 5'd1);
        ST_RDATA: begin
          rd_shift = sclk_fall && !bitcnt[4];
          rd_tail  = sclk_fall && bitcnt[4];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt    <= 5'd0;
      ones_cnt  <= 6'd0;
      cmd_sh    <= 7'd0;
      wr_sh     <= 15'd0;
      shift_out <= 16'h0000;
      cur_addr  <= 3'd0;
      dout_q    <= 1'b1;
    end else begin
      if (cs_s)
        ones_cnt <= 6'd0;
      else if (sclk_rise)
        ones_cnt <= !din_s ? 6'd0 :
                    (ones_cnt == ONES_FOR_RST) ? ONES_FOR_RST : ones_cnt + 6'd1;

      case (state)
        ST_IDLE: bitcnt <= 5'd0;
        ST_CMD: begin
          if (sclk_rise) begin
            cmd_sh <= cmd_byte[6:0];
            bitcnt <= cmd_done ? 5'd0 : bitcnt + 5'd1;
          end
          if (cmd_done) begin
            cur_addr  <= cmd_addr;
            shift_out <= rd_word;
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
            wr_sh  <= wr_word[14:0];
            bitcnt <= bitcnt + 5'd1;
          end
        end
        ST_RDATA: begin
          if (rd_shift) begin
            shift_out <= {shift_out[14:0], 1'b0};
            bitcnt    <= bitcnt + 5'd1;
          end
        end
        default: ;
      endcase

      if (cs_s || state != ST_RDATA)
        dout_q <= 1'b1;
      else if (rd_shift)
        dout_q <= shift_out[15];
      else if (rd_tail)
        dout_q <= 1'b0;
    end
  end

  // Register file; a serial reset restores it exactly as the reset pin does.
  always_ff @(posedge clk) begin
    if (reset || ones_hit) begin
      temp_q   <= 16'h0000;
      config_q <= 8'h00;
      tcrit_q  <= TCRIT_DEFAULT;
      thyst_q  <= THYST_DEFAULT;
      thigh_q  <= THIGH_DEFAULT;
      tlow_q   <= TLOW_DEFAULT;
      rdy_n    <= STATUS_RESET[7];
    end else begin
      if (temp_valid)
        temp_q <= temp_in;
      if (temp_valid)
        rdy_n <= 1'b0;
      else if (rd_done)
        rdy_n <= 1'b1;
      if (wr_last) begin
        case (cur_addr)
          ADDR_CONFIG: config_q <= wr_word[7:0];
          ADDR_THYST:  thyst_q  <= wr_word[7:0];
          ADDR_TCRIT:  tcrit_q  <= wr_word;
          ADDR_THIGH:  thigh_q  <= wr_word;
          ADDR_TLOW:   tlow_q   <= wr_word;
          default: ;
        endcase
      end
    end
  end

  assign spi.dout    = dout_q;
  assign spi.dout_oe = ~cs_s;
  assign config_reg  = config_q;

  logic unused_sigs;
  assign unused_sigs = &{1'b0, sclk_s, cs_rise, cs_fall, din_rise, din_fall, cmd_byte[7]};

endmodule

`default_nettype wire

// File: tb/tb_adt7320_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_adt7320_responder
// Brief   : Scoreboard bench driving a mode-3 SPI master against the ADT7320 emulator.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_adt7320_responder;

  localparam realtime HP_SLOW = 1000.0;
  localparam realtime HP_STD  = 250.0;
  localparam realtime HP_FAST = 18.5;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] temp_in;
  logic        temp_valid;
  logic [7:0]  config_reg;

  adt7320_responder_if spi_bus();

  adt7320_responder dut (
    .clk        (clk),
    .reset      (reset),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .spi        (spi_bus),
    .config_reg (config_reg)
  );

  always #5 clk = ~clk;

  string       exp_name_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] act_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic expect_val(input string name, input logic [15:0] v);
    exp_name_q.push_back(name);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [15:0] v);
    act_q.push_back(v);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (act_q.size() > 0 && exp_q.size() > 0) begin
        string       nm;
        logic [15:0] e, a;
        nm = exp_name_q.pop_front();
        e  = exp_q.pop_front();
        a  = act_q.pop_front();
        n_cmp++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", nm, a, e);
        end
      end
    end
  end

  task automatic spi_frame(input int n, input logic [47:0] tx, input realtime hp,
                           output logic [47:0] rx);
    logic [47:0] acc;
    acc = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bus.sclk = 1'b0;
      spi_bus.din  = tx[i];
      #hp;
      spi_bus.sclk = 1'b1;
      acc = {acc[46:0], spi_bus.dout};
      #hp;
    end
    rx = acc;
  endtask

  task automatic cs_low(input realtime hp);
    @(negedge clk);
    #1;
    spi_bus.cs = 1'b0;
    #(hp < 100.0 ? 100.0 : hp);
  endtask

  task automatic cs_high(input realtime hp);
    spi_bus.cs  = 1'b1;
    spi_bus.din = 1'b0;
    #hp;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input logic [15:0] data, input int ndata,
                         input realtime hp, output logic [15:0] rd);
    logic [47:0] tx, rx;
    tx = ({40'd0, cmd} << ndata) | ({32'd0, data} >> (16 - ndata));
    cs_low(hp);
    spi_frame(8 + ndata, tx, hp, rx);
    cs_high(hp);
    rd = rx[15:0];
  endtask

  task automatic rd_reg(input logic [2:0] a, input string name, input logic [15:0] exp,
                        input realtime hp);
    logic [15:0] r;
    expect_val(name, exp);
    spi_txn(8'h40 | {2'b00, a, 3'b000}, 16'h0000, 16, hp, r);
    observe(r);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] data, input int nbits,
                        input realtime hp);
    logic [15:0] r;
    spi_txn({2'b00, a, 3'b000}, data, nbits, hp, r);
  endtask

  task automatic raw_txn(input int n, input logic [47:0] tx, input realtime hp);
    logic [47:0] rx;
    cs_low(hp);
    spi_frame(n, tx, hp, rx);
    cs_high(hp);
  endtask

  task automatic check_pins(input string name, input logic [15:0] exp, input int which);
    @(negedge clk);
    n_cmp++;
    case (which)
      0: begin
        if (spi_bus.dout !== exp[0]) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", name, spi_bus.dout, exp[0]);
        end
      end
      1: begin
        if (spi_bus.dout_oe !== exp[0]) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", name, spi_bus.dout_oe, exp[0]);
        end
      end
      default: begin
        if (config_reg !== exp[7:0]) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", name, config_reg, exp[7:0]);
        end
      end
    endcase
  endtask

  task automatic pulse_temp(input logic [15:0] v);
    @(negedge clk);
    temp_in    = v;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] rx;
    reset        = 1'b1;
    temp_in      = 16'h0000;
    temp_valid   = 1'b0;
    spi_bus.cs   = 1'b1;
    spi_bus.sclk = 1'b1;
    spi_bus.din  = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    check_pins("reset_dout", 16'h0001, 0);
    check_pins("reset_dout_oe", 16'h0000, 1);
    check_pins("reset_config", 16'h0000, 2);

    rd_reg(3'd0, "status_after_reset", 16'h9000, HP_SLOW);
    rd_reg(3'd3, "id_read", 16'hC300, HP_SLOW);

    pulse_temp(16'h0C80);
    rd_reg(3'd0, "status_rdy_cleared", 16'h0000, HP_STD);
    rd_reg(3'd2, "temp_read", 16'h0C80, HP_STD);
    rd_reg(3'd0, "status_rdy_set", 16'h8000, HP_STD);

    wr_reg(3'd6, 16'h1234, 16, HP_STD);
    rd_reg(3'd6, "thigh_readback", 16'h1234, HP_STD);
    pulse_temp(16'h1234);
    rd_reg(3'd0, "status_eq_thigh", 16'h2000, HP_STD);
    pulse_temp(16'hFF00);
    rd_reg(3'd0, "status_negative", 16'h1000, HP_STD);
    pulse_temp(16'h4980);
    rd_reg(3'd0, "status_eq_tcrit", 16'h6000, HP_STD);

    wr_reg(3'd1, 16'hA500, 8, HP_STD);
    check_pins("config_write", 16'h00A5, 2);
    rd_reg(3'd1, "config_readback", 16'hA500, HP_STD);
    wr_reg(3'd2, 16'hBEEF, 16, HP_STD);
    rd_reg(3'd2, "temp_write_ignored", 16'h4980, HP_STD);

    wr_reg(3'd4, 16'h1111, 10, HP_STD);
    rd_reg(3'd4, "tcrit_partial_write", 16'h4980, HP_STD);
    wr_reg(3'd5, 16'h0A00, 8, HP_STD);
    rd_reg(3'd5, "thyst_readback", 16'h0A00, HP_STD);

    wr_reg(3'd1, 16'h4000, 8, HP_FAST);
    check_pins("config_fast_write", 16'h0040, 2);

    raw_txn(32, 48'h0000_FFFF_FFFF, HP_STD);
    check_pins("serial_reset_config", 16'h0000, 2);
    rd_reg(3'd6, "serial_reset_thigh", 16'h2000, HP_STD);
    rd_reg(3'd5, "serial_reset_thyst", 16'h0500, HP_STD);
    rd_reg(3'd0, "serial_reset_status", 16'h9000, HP_STD);

    wr_reg(3'd1, 16'h4000, 8, HP_STD);
    raw_txn(32, 48'h0000_FFFF_FFFE, HP_STD);
    check_pins("no_serial_reset_31", 16'h0040, 2);

    wr_reg(3'd6, 16'h1234, 16, HP_STD);
    cs_low(HP_STD);
    spi_frame(13, {35'd0, 8'h48, 5'd0}, HP_STD, rx);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_pins("midread_reset_dout", 16'h0001, 0);
    check_pins("midread_reset_dout_oe", 16'h0001, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_pins("midread_reset_config", 16'h0000, 2);
    cs_high(HP_STD);
    check_pins("after_cs_dout_oe", 16'h0000, 1);
    check_pins("after_cs_dout", 16'h0001, 0);
    rd_reg(3'd6, "midread_reset_thigh", 16'h2000, HP_STD);
    rd_reg(3'd3, "midread_reset_id", 16'hC300, HP_STD);

    for (int i = 0; i < 200 && (exp_q.size() != 0 || act_q.size() != 0); i++)
      @(negedge clk);
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got nothing expected %h", exp_name_q.pop_front(), exp_q.pop_front());
    end
    while (act_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL extra_response: got %h expected nothing", act_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
